// File: rtl/tic_toc_pkg.sv
// Shared types and constants for the tic_toc period-measurement block.
package tic_toc_pkg;

  typedef enum logic {
    WAIT_TIC = 1'b0,
    COUNT    = 1'b1
  } tic_toc_state_e;

  localparam int unsigned TICTOC_WIDTH = 16;

  // A result equal to this value means "period >= 65535 cycles".
  localparam logic [TICTOC_WIDTH-1:0] TICTOC_SAT = '1;

endpackage

// File: rtl/tic_toc_edge_sync.sv
// Optional SYNC_STAGES-deep synchronizer followed by a registered rising-edge detector.
// The synchronizer is compiled in only when TICTOC_INPUT_SYNC_EN is defined.
module tic_toc_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic level;
  logic level_q;

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("tic_toc_edge_sync: SYNC_STAGES must be at least 2");
  end

`ifdef TICTOC_INPUT_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
`else
  assign level = async_in;
`endif

  // Pulse is registered so a rise is seen one cycle after the conditioned level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/tic_toc.sv
// Measures Clk cycles between consecutive TimeStamp rising edges and holds the
// result until acknowledged. Define TICTOC_INPUT_SYNC_EN to synchronize both inputs.
module tic_toc
  import tic_toc_pkg::*;
#(
  parameter int unsigned WIDTH       = TICTOC_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             TimeStamp,
  input  logic             TicToc_ASCII_TX_done,
  output logic [WIDTH-1:0] TicToc_Arr,
  output logic             TicToc_ready
);

  tic_toc_state_e   state;
  tic_toc_state_e   state_next;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] measure;
  logic [WIDTH-1:0] arr_next;
  logic             ready_next;
  logic             capture;
  logic             load;
  logic             ts_rise;
  logic             done_rise;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] value);
    return (value == '1) ? value : value + WIDTH'(1);
  endfunction

  tic_toc_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ts_sync (
    .clk     (Clk),
    .rst_n   (Reset),
    .async_in(TimeStamp),
    .rise    (ts_rise)
  );

  tic_toc_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_done_sync (
    .clk     (Clk),
    .rst_n   (Reset),
    .async_in(TicToc_ASCII_TX_done),
    .rise    (done_rise)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    case (state)
      WAIT_TIC: begin
        count_next = '0;
        if (ts_rise) begin
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (ts_rise) begin
          capture    = 1'b1;
          count_next = '0;
        end else begin
          count_next = sat_inc(count);
        end
      end
      default: begin
        state_next = WAIT_TIC;
        count_next = '0;
      end
    endcase

    // The counter lags the true period by one, so the captured value is count+1.
    measure    = sat_inc(count);
    load       = capture & (~TicToc_ready | done_rise);
    arr_next   = load ? measure : TicToc_Arr;
    ready_next = load ? 1'b1 : (done_rise ? 1'b0 : TicToc_ready);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= WAIT_TIC;
      count        <= '0;
      TicToc_Arr   <= '0;
      TicToc_ready <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      TicToc_Arr   <= arr_next;
      TicToc_ready <= ready_next;
    end
  end

endmodule

// File: tb/tb_tic_toc.sv
// Scoreboard bench for tic_toc: stimulus pushes expected periods, a monitor pops on each new result.
module tb_tic_toc;
  import tic_toc_pkg::*;

  localparam int unsigned SS = 2;
`ifdef TICTOC_INPUT_SYNC_EN
  localparam int unsigned ACK_LAT = SS + 2;
`else
  localparam int unsigned ACK_LAT = 2;
`endif

  logic        Clk;
  logic        Reset;
  logic        TimeStamp;
  logic        TicToc_ASCII_TX_done;
  logic [15:0] TicToc_Arr;
  logic        TicToc_ready;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned n_exp = 0;
  int unsigned n_got = 0;

  // Bench-side model of the result slot
  bit          armed   = 1'b0;
  bit          m_ready = 1'b0;
  logic [15:0] m_arr   = '0;
  int unsigned last_rise = 0;
  logic [15:0] exp_q[$];

  tic_toc #(
    .WIDTH      (16),
    .SYNC_STAGES(SS)
  ) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .TimeStamp           (TimeStamp),
    .TicToc_ASCII_TX_done(TicToc_ASCII_TX_done),
    .TicToc_Arr          (TicToc_Arr),
    .TicToc_ready        (TicToc_ready)
  );

  initial Clk = 1'b0;
  always #25 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge Clk);
  endtask

  // Raise TimeStamp (optionally with the ack) and record what the DUT should produce.
  task automatic do_rise(input bit with_ack);
    int unsigned period;
    TimeStamp = 1'b1;
    if (with_ack) TicToc_ASCII_TX_done = 1'b1;
    if (armed) begin
      period = cyc - last_rise;
      if (period > 65535) period = 65535;
      if (!m_ready || with_ack) begin
        m_arr = period[15:0];
        exp_q.push_back(m_arr);
        n_exp++;
        m_ready = 1'b1;
      end
    end else if (with_ack) begin
      m_ready = 1'b0;
    end
    armed     = 1'b1;
    last_rise = cyc;
  endtask

  task automatic mark(input int unsigned p);
    do_rise(1'b0);
    tick(p / 2);
    TimeStamp = 1'b0;
    tick(p - p / 2);
  endtask

  task automatic ack();
    TicToc_ASCII_TX_done = 1'b0;
    tick(2);
    check("ack_pre_ready", {31'd0, TicToc_ready}, 32'd1);
    TicToc_ASCII_TX_done = 1'b1;
    tick(ACK_LAT - 1);
    check("ack_hold_ready", {31'd0, TicToc_ready}, 32'd1);
    tick(1);
    check("ack_ready_low", {31'd0, TicToc_ready}, 32'd0);
    check("ack_arr_kept", {16'd0, TicToc_Arr}, {16'd0, m_arr});
    m_ready = 1'b0;
  endtask

  // Monitor: a new result is a ready rise, or a changed value while ready stays high.
  initial begin : monitor
    logic        prev_ready;
    logic [15:0] prev_arr;
    logic [15:0] exp;
    prev_ready = 1'b0;
    prev_arr   = '0;
    forever begin
      @(negedge Clk);
      if (TicToc_ready === 1'b1 && (prev_ready !== 1'b1 || TicToc_Arr !== prev_arr)) begin
        n_got++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_unexpected: got %0h expected no result", TicToc_Arr);
        end else begin
          exp = exp_q.pop_front();
          check("sb_result", {16'd0, TicToc_Arr}, {16'd0, exp});
        end
      end
      prev_ready = TicToc_ready;
      prev_arr   = TicToc_Arr;
    end
  end

  initial begin
    Reset                = 1'b0;
    TimeStamp            = 1'b0;
    TicToc_ASCII_TX_done = 1'b0;

    // Reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      tick(1);
      TimeStamp            = ~TimeStamp;
      TicToc_ASCII_TX_done = ~TicToc_ASCII_TX_done;
      check("rst_arr", {16'd0, TicToc_Arr}, 32'd0);
      check("rst_ready", {31'd0, TicToc_ready}, 32'd0);
    end
    TimeStamp            = 1'b0;
    TicToc_ASCII_TX_done = 1'b0;
    tick(2);
    Reset = 1'b1;
    tick(2);

    // Steady period of 4 cycles; first edge is only a tic
    for (int i = 0; i < 5; i++) mark(4);
    check("steady_ready", {31'd0, TicToc_ready}, 32'd1);
    check("steady_arr", {16'd0, TicToc_Arr}, 32'h4);

    // Unacknowledged result survives later tocs
    mark(4);
    mark(7);
    mark(5);
    check("drop_arr", {16'd0, TicToc_Arr}, 32'h4);
    check("drop_ready", {31'd0, TicToc_ready}, 32'd1);

    ack();
    mark(6);
    check("reload_ready", {31'd0, TicToc_ready}, 32'd1);

    // Toc and ack rise together: the new value wins
    TicToc_ASCII_TX_done = 1'b0;
    tick(2);
    do_rise(1'b1);
    tick(3);
    TimeStamp = 1'b0;
    tick(5);
    check("simul_ready", {31'd0, TicToc_ready}, 32'd1);
    check("simul_arr", {16'd0, TicToc_Arr}, {16'd0, m_arr});

    ack();

    // Reset in the middle of a count
    mark(5);
    tick(3);
    #10;
    Reset = 1'b0;
    #1;
    check("rst_mid_arr", {16'd0, TicToc_Arr}, 32'd0);
    check("rst_mid_ready", {31'd0, TicToc_ready}, 32'd0);
    TicToc_ASCII_TX_done = 1'b0;
    armed   = 1'b0;
    m_ready = 1'b0;
    m_arr   = '0;
    exp_q.delete();
    tick(2);
    Reset = 1'b1;
    tick(2);

    // Saturation: a period longer than the counter range
    mark(4);
    tick(70000);
    mark(4);
    tick(4);
    check("sat_ready", {31'd0, TicToc_ready}, 32'd1);
    check("sat_arr", {16'd0, TicToc_Arr}, {16'd0, TICTOC_SAT});

    tick(10);
    check("sb_drain", exp_q.size(), 32'd0);
    check("sb_count", n_got, n_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
